// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, single-outstanding memory read and instruction register load strobe.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter logic [ADDR_WIDTH-1:0] PC_STEP        = ADDR_WIDTH'(4),
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  ir_load,
    output logic [DATA_WIDTH-1:0] ir_data,
    output logic [ADDR_WIDTH-1:0] ir_pc,
    output logic                  fetch_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   buf_pc;
    logic [DATA_WIDTH-1:0]   buf_data;
    logic                    timeout;

    function automatic logic [ADDR_WIDTH-1:0] step_pc(input logic [ADDR_WIDTH-1:0] a);
        return a + PC_STEP;
    endfunction

    assign mem_req  = (state == S_FETCH) || (state == S_DISCARD);
    assign mem_addr = addr;

`ifdef FETCH_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // Counts consecutive waiting cycles; any response, redirect or idle cycle restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            fetch_error <= 1'b0;
        end else if (!mem_req || mem_ready || redirect) begin
            wd_cnt <= '0;
        end else if (wd_cnt == WD_LAST) begin
            wd_cnt      <= '0;
            fetch_error <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = mem_req && !mem_ready && !redirect && (wd_cnt == WD_LAST);
`else
    assign fetch_error = 1'b0;
    assign timeout     = 1'b0;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            addr    <= RESET_PC;
            ir_load <= 1'b0;
            ir_data <= '0;
            ir_pc   <= '0;
        end else begin
            ir_load <= 1'b0;
            if (timeout) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        pc   <= redirect ? redirect_pc : pc;
                        addr <= redirect ? redirect_pc : pc;
                        // A latched watchdog error parks the fetcher here until reset.
                        if (!fetch_error) state <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (redirect) begin
                            pc <= redirect_pc;
                            if (mem_ready) addr  <= redirect_pc;
                            else           state <= S_DISCARD;
                        end else if (mem_ready) begin
                            pc <= step_pc(addr);
                            if (stall) begin
                                state <= S_HOLD;
                            end else begin
                                addr    <= step_pc(addr);
                                ir_load <= 1'b1;
                                ir_data <= mem_rdata;
                                ir_pc   <= addr;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (redirect) begin
                            pc    <= redirect_pc;
                            addr  <= redirect_pc;
                            state <= S_FETCH;
                        end else if (!stall) begin
                            ir_load <= 1'b1;
                            ir_data <= buf_data;
                            ir_pc   <= buf_pc;
                            addr    <= pc;
                            state   <= S_FETCH;
                        end
                    end
                    S_DISCARD: begin
                        if (redirect) pc <= redirect_pc;
                        if (mem_ready) begin
                            addr  <= redirect ? redirect_pc : pc;
                            state <= S_FETCH;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Word parked while the instruction register is stalled.
    always_ff @(posedge clk) begin
        if (state == S_FETCH && mem_ready && stall && !redirect) begin
            buf_data <= mem_rdata;
            buf_pc   <= addr;
        end
    end

endmodule
